// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: frames a byte stream as length/payload/checksum,
// packs little-endian words into imem port A and releases the core once a load checks out.
module program_loader #(
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [15:0] MAX_WORDS = 16'(2 ** ADDR_WIDTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_SUM, S_DONE, S_ERR} state_t;

  state_t                  state_q;
  logic [7:0]              len_lo_q;
  logic [CW-1:0]           n_words_q;
  logic [CW-1:0]           word_cnt_q;
  logic [1:0]              byte_idx_q;
  logic [23:0]             word_buf_q;
  logic [7:0]              csum_q;
  logic [GW-1:0]           gap_q;
  logic [ADDR_WIDTH-1:0]   imem_address_q;
  logic [31:0]             imem_data_q;
  logic                    imem_wren_q;
  logic                    core_reset_q;
  logic                    load_done_q;
  logic                    load_error_q;

  logic                    xfer;
  logic                    gap_active;
  logic [15:0]             len_d;
  logic [31:0]             word_d;
  logic [CW-1:0]           word_cnt_d;

  assign byte_ready = (state_q inside {S_LEN0, S_LEN1, S_DATA, S_SUM}) && !reload;
  assign xfer       = byte_valid && byte_ready;
  assign gap_active = state_q inside {S_LEN1, S_DATA, S_SUM};
  assign len_d      = {byte_data, len_lo_q};
  assign word_d     = {byte_data, word_buf_q};
  assign word_cnt_d = word_cnt_q + CW'(1);

  assign imem_address = imem_address_q;
  assign imem_data    = imem_data_q;
  assign imem_wren    = imem_wren_q;
  assign core_reset   = core_reset_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_LEN0;
      len_lo_q       <= '0;
      n_words_q      <= '0;
      word_cnt_q     <= '0;
      byte_idx_q     <= '0;
      word_buf_q     <= '0;
      csum_q         <= '0;
      gap_q          <= '0;
      imem_address_q <= '0;
      imem_data_q    <= '0;
      imem_wren_q    <= 1'b0;
      core_reset_q   <= 1'b1;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      imem_wren_q <= 1'b0;
      if (reload) begin
        // address/data keep their last value; only the load bookkeeping restarts
        state_q      <= S_LEN0;
        word_cnt_q   <= '0;
        byte_idx_q   <= '0;
        csum_q       <= '0;
        gap_q        <= '0;
        core_reset_q <= 1'b1;
        load_done_q  <= 1'b0;
        load_error_q <= 1'b0;
      end else if (gap_active && !xfer && gap_q == GAP_LAST) begin
        state_q      <= S_ERR;
        gap_q        <= '0;
        load_error_q <= 1'b1;
      end else begin
        if (gap_active) gap_q <= xfer ? '0 : gap_q + GW'(1);
        case (state_q)
          S_LEN0: if (xfer) begin
            len_lo_q <= byte_data;
            state_q  <= S_LEN1;
          end
          S_LEN1: if (xfer) begin
            if (len_d == 16'd0 || len_d > MAX_WORDS) begin
              state_q      <= S_ERR;
              load_error_q <= 1'b1;
            end else begin
              n_words_q <= len_d[CW-1:0];
              state_q   <= S_DATA;
            end
          end
          S_DATA: if (xfer) begin
            csum_q     <= csum_q ^ byte_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_buf_q[7:0]   <= byte_data;
              2'd1: word_buf_q[15:8]  <= byte_data;
              2'd2: word_buf_q[23:16] <= byte_data;
              default: begin
                imem_wren_q    <= 1'b1;
                imem_address_q <= word_cnt_q[ADDR_WIDTH-1:0];
                imem_data_q    <= word_d;
                word_cnt_q     <= word_cnt_d;
                if (word_cnt_d == n_words_q) state_q <= S_SUM;
              end
            endcase
          end
          S_SUM: if (xfer) begin
            if (byte_data == csum_q) begin
              state_q      <= S_DONE;
              core_reset_q <= 1'b0;
              load_done_q  <= 1'b1;
            end else begin
              state_q      <= S_ERR;
              load_error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized, self-checking bench for program_loader; expectations come from parsing
// each generated frame directly (length, words, XOR checksum).
module tb_program_loader;
  localparam int AW = 7;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          reload = 1'b0;
  logic          byte_ready;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_data;
  logic          imem_wren;
  logic          core_reset;
  logic          load_done;
  logic          load_error;

  program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .imem_address(imem_address),
    .imem_data(imem_data), .imem_wren(imem_wren), .core_reset(core_reset),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          xfer_cyc[$];
  logic [7:0]  frame[$];

  always @(negedge clock) begin
    if (imem_wren === 1'b1) begin
      wr_addr.push_back(int'(imem_address));
      wr_data.push_back(imem_data);
      wr_cyc.push_back(cyc);
    end
  end

  int cmp_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); xfer_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit r;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int w = 0; w < 40 && !ok; w++) begin
      #1 r = byte_ready;
      @(posedge clock);
      @(negedge clock);
      if (r) begin
        ok = 1'b1;
        xfer_cyc.push_back(cyc);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int nbytes, input int max_gap);
    bit ok;
    for (int i = 0; i < nbytes; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
      send_byte(frame[i], ok);
      if (!ok) begin
        cmp_cnt++;
        fail_cnt++;
        $error("FAIL byte_accept: byte %0d never accepted, required accept within 40 cycles", i);
        return;
      end
    end
  endtask

  // Length N, N random words, XOR checksum (optionally corrupted).
  task automatic build_frame(input int n, input bit bad_sum);
    logic [7:0] s = 8'h00;
    logic [7:0] b;
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    if (n == 0 || n > 2 ** AW) return;
    for (int j = 0; j < 4 * n; j++) begin
      b = 8'($urandom);
      s ^= b;
      frame.push_back(b);
    end
    frame.push_back(bad_sum ? (s ^ 8'h5A) : s);
  endtask

  function automatic int consumed_bytes();
    int n = int'(frame[0]) | (int'(frame[1]) << 8);
    return (n == 0 || n > 2 ** AW) ? 2 : 4 * n + 3;
  endfunction

  task automatic check_frame(input string tag);
    int n, nexp;
    bit len_ok, sum_ok;
    logic [7:0] s = 8'h00;
    @(negedge clock);
    n      = int'(frame[0]) | (int'(frame[1]) << 8);
    len_ok = (n != 0) && (n <= 2 ** AW);
    nexp   = len_ok ? n : 0;
    sum_ok = 1'b0;
    if (len_ok) begin
      for (int j = 0; j < 4 * n; j++) s ^= frame[2 + j];
      sum_ok = (s == frame[2 + 4 * n]);
    end
    $display("frame %s: N=%0d writes=%0d expect_done=%0d", tag, n, wr_addr.size(), len_ok && sum_ok);
    chk({tag, "_nwrites"}, wr_addr.size(), nexp);
    for (int i = 0; i < nexp && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], i);
      chk({tag, "_data"}, wr_data[i], {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]});
      chk({tag, "_lat"}, wr_cyc[i], xfer_cyc[2 + 4 * i + 3]);
    end
    chk({tag, "_done"}, load_done, len_ok && sum_ok);
    chk({tag, "_error"}, load_error, !(len_ok && sum_ok));
    chk({tag, "_core_reset"}, core_reset, !(len_ok && sum_ok));
    chk({tag, "_ready"}, byte_ready, 1'b0);
  endtask

  task automatic do_reload();
    reload     = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    #1 chk("ready_during_reload", byte_ready, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reload     = 1'b0;
    byte_valid = 1'b0;
    clear_logs();
    chk("reload_done", load_done, 1'b0);
    chk("reload_error", load_error, 1'b0);
    chk("reload_core_reset", core_reset, 1'b1);
  endtask

  task automatic load_test1(input logic [7:0] sum);
    frame.delete();
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, sum};
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_wren", imem_wren, 1'b0);
    chk("rst_addr", imem_address, '0);
    chk("rst_data", imem_data, 32'h0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_done", load_done, 1'b0);
    chk("rst_error", load_error, 1'b0);
    chk("rst_ready", byte_ready, 1'b1);
    clear_logs();

    load_test1(8'h20);
    chk("t1_model_sum", {24'h0, frame[10]}, 32'h20);
    send_frame(consumed_bytes(), 3);
    check_frame("t1");
    if (wr_data.size() == 2) begin
      chk("t1_word0", wr_data[0], 32'h0000_0013);
      chk("t1_word1", wr_data[1], 32'h00A0_0093);
    end

    do_reload();
    load_test1(8'h21);
    send_frame(consumed_bytes(), 3);
    check_frame("t2_badsum");

    do_reload();
    build_frame(0, 1'b0);
    send_frame(consumed_bytes(), 2);
    check_frame("t3_len0");
    do_reload();
    build_frame(129, 1'b0);
    send_frame(consumed_bytes(), 2);
    check_frame("t3_len129");
    do_reload();
    build_frame(128, 1'b0);
    send_frame(consumed_bytes(), 1);
    check_frame("t3_len128");

    // timeout: gap measured from the first data byte's transfer
    do_reload();
    frame.delete();
    frame = '{8'h02, 8'h00, 8'hAA};
    send_frame(3, 2);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clock);
      chk($sformatf("t4_timeout_k%0d", k), load_error, (k >= TO));
    end
    chk("t4_nwrites", wr_addr.size(), 0);
    chk("t4_core_reset", core_reset, 1'b1);
    $display("timeout: load_error observed at +%0d cycles", TO);

    do_reload();
    build_frame(3, 1'b0);
    send_frame(8, 1);
    do_reload();
    load_test1(8'h20);
    send_frame(consumed_bytes(), 2);
    check_frame("t5_after_reload");

    for (int r = 0; r < 5; r++) begin
      do_reload();
      build_frame($urandom_range(1, 8), ($urandom_range(0, 3) == 0));
      send_frame(consumed_bytes(), TO - 6);
      check_frame($sformatf("t6_rand%0d", r));
    end

    do_reload();
    build_frame(4, 1'b0);
    send_frame(9, 3);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t6_wren_in_reset", imem_wren, 1'b0);
    end
    reset = 1'b0;
    chk("t6_rst_core_reset", core_reset, 1'b1);
    chk("t6_rst_done", load_done, 1'b0);
    chk("t6_rst_addr", imem_address, '0);
    clear_logs();
    build_frame($urandom_range(2, 10), 1'b0);
    send_frame(consumed_bytes(), TO - 6);
    check_frame("t6_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
